axis_fifo_rr_scheduler: RTL and testbench
=========================================

Name: axis_fifo_rr_scheduler

Overview:
- Shares one AXI4-Stream master port between NUM_SRC first-word-fall-through FIFOs.
- Grants one FIFO at a time using round-robin arbitration.
- Holds the grant for a whole packet of pkt_len beats, asserts tlast on the final beat, then rotates priority.
- Sits between the per-channel capture FIFOs and the downstream stream sink. Packets from different sources never interleave.

Parameters:
- NUM_SRC, 4, number of FIFO sources (≥2).
- DATA_WIDTH, 64, stream data width in bits.
- LEN_WIDTH, 16, width of the packet-length configuration.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  allows new packets to start. Does not abort a packet in progress.
- pkt_len  in  LEN_WIDTH  beats per packet; sampled at grant. 0 is treated as 1.
- fifo_rd_data  in  NUM_SRC x DATA_WIDTH  FWFT head word of each FIFO.
- fifo_empty  in  NUM_SRC  empty flag of each FIFO.
- fifo_rd_en  out  NUM_SRC  pop strobe per FIFO.
- axis  master  interface  axi4s_if.master stream output (tvalid, tready, tdata, tkeep, tlast).
- busy  out  1  high while in the SEND state.
- grant_idx  out  $clog2(NUM_SRC)  index of the current or last granted source.
- pkt_done  out  1  one-cycle pulse, registered, the cycle after the tlast handshake.

Behaviour:
- Reset state:
  - state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0, len_q=1, busy=0, pkt_done=0.
  - fifo_rd_en=0; tvalid=0, tlast=0, tdata=0 and tkeep=all-ones, while IDLE.
- State IDLE:
  - tvalid=0 and all fifo_rd_en=0.
  - When enable=1 and any fifo_empty bit is 0, grant the first non-empty source at or after rr_ptr, modulo NUM_SRC.
  - On that grant, register grant_idx, len_q=max(pkt_len,1) and beat_cnt=0, then go to SEND.
  - The grant costs exactly 1 cycle. tvalid is first possible on the next cycle.
- State SEND (combinational output path, no output register):
  - tvalid = !fifo_empty[grant_idx].
  - tdata = fifo_rd_data[grant_idx].
  - tkeep = all-ones.
  - tlast = (beat_cnt == len_q-1).
  - fifo_rd_en[grant_idx] = tvalid & tready. All other fifo_rd_en bits are 0.
- Beat handshake (tvalid & tready) in SEND:
  - If it is not the last beat, beat_cnt increments.
  - On the last beat, go to IDLE, set rr_ptr = (grant_idx+1) mod NUM_SRC, and pulse pkt_done next cycle.
- Granted FIFO empties mid-packet: tvalid drops and the grant is held (no timeout, no switch). Transfer resumes when data arrives.
- enable falls mid-packet: the packet completes normally, and no new grant is made afterwards.
- pkt_len changes mid-packet: ignored; len_q governs the packet.
- tready low with tvalid high: tdata and tlast stay stable, because FWFT data is stable while rd_en=0.
- Back-to-back packets: at least one IDLE cycle between the tlast beat and the next packet's first beat. Maximum throughput is len_q/(len_q+1).
- Single non-empty source: it is re-granted repeatedly, because rr_ptr rotation skips the empty sources.
- Counters: beat_cnt is LEN_WIDTH bits. len_q = 2^LEN_WIDTH-1 must work with no overflow.
- Reset asserted mid-packet: immediate return to reset state. The partial packet is abandoned without tlast, and the downstream must tolerate this.

Decomposition:
- Package axis_sched_pkg holds:
  - the state enum (IDLE, SEND);
  - a function computing the index width as $clog2 with a minimum of 1.
- Sub-module rr_arbiter is purely combinational. Inputs are the request vector and rr_ptr; outputs are grant_valid and grant_index. It implements the priority rotation with a double-width mask scan.
- The top level holds the FSM, beat counter, muxing and pkt_done register.

Test Plan:
- Single source, tready=1, pkt_len=4:
  - FIFO0 holds 8 words (A0..A7).
  - Required: two packets, A0..A3 and A4..A7.
  - tlast on A3 and A7; one IDLE cycle between packets.
  - pkt_done pulses twice; fifo_rd_en[0] asserts exactly 8 times.
- Round-robin fairness, pkt_len=2:
  - All 4 FIFOs non-empty with 4 words each.
  - Required grant order: 0,1,2,3,0,1,2,3.
  - Each packet is 2 beats with tlast on the 2nd.
- Backpressure:
  - tready toggles 1,0,0,1 during a 3-beat packet.
  - Required: tdata and tlast stable while tready=0.
  - No fifo_rd_en during stalled cycles; exactly 3 pops in total.
- Starvation mid-packet:
  - FIFO1 holds 2 words, pkt_len=5, 3 more words pushed 10 cycles later.
  - Required: tvalid low during the gap and grant_idx stays 1, even though FIFO2 is non-empty.
  - The packet ends with tlast on beat 5.
- enable and pkt_len edge cases:
  - pkt_len=0 gives 1-beat packets with tlast on every beat.
  - enable dropped after beat 1 of a 4-beat packet: the packet still completes, then busy=0 with no further grants.
- Asynchronous reset mid-packet (beat 2 of 4):
  - Required: tvalid=0 and all fifo_rd_en=0 immediately.
  - After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/axis_sched_pkg.sv
// Shared types and helpers for the AXI4-Stream FIFO round-robin scheduler.
package axis_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index width for n sources; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axi4s_if.sv
// Minimal AXI4-Stream bundle carrying tvalid/tready/tdata/tkeep/tlast.
interface axi4s_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after rr_ptr, wrapping.
module rr_arbiter
    import axis_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned IW      = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               grant_valid,
    output logic [IW-1:0]      grant_index
);

    localparam int SCAN_W = 2 * int'(NUM_SRC);

    logic [SCAN_W-1:0] req2;
    logic [SCAN_W-1:0] mask;
    logic [SCAN_W-1:0] masked;

    // Doubled request vector with bits below rr_ptr masked; the lowest surviving bit wins.
    always_comb begin
        req2        = {req, req};
        mask        = '0;
        grant_valid = 1'b0;
        grant_index = '0;
        for (int i = 0; i < SCAN_W; i++) begin
            mask[i] = (i >= int'(rr_ptr));
        end
        masked = req2 & mask;
        for (int i = SCAN_W - 1; i >= 0; i--) begin
            if (masked[i]) begin
                grant_valid = 1'b1;
                grant_index = IW'(i % int'(NUM_SRC));
            end
        end
    end

endmodule

// File: rtl/axis_fifo_rr_scheduler.sv
// Round-robin packet scheduler sharing one AXI4-Stream master between FWFT FIFOs.
module axis_fifo_rr_scheduler
    import axis_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                enable,
    input  logic [LEN_WIDTH-1:0]                pkt_len,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic [NUM_SRC-1:0]                  fifo_empty,
    output logic [NUM_SRC-1:0]                  fifo_rd_en,
    axi4s_if.master                             axis,
    output logic                                busy,
    output logic [idx_width(NUM_SRC)-1:0]       grant_idx,
    output logic                                pkt_done
);

    localparam int unsigned IW = idx_width(NUM_SRC);

    state_t               state_q;
    state_t               state_d;
    logic [IW-1:0]        rr_ptr;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 arb_valid;
    logic [IW-1:0]        arb_index;
    logic                 start;
    logic                 send_valid;
    logic                 beat_hs;
    logic                 last_beat;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_arb (
        .req         (~fifo_empty),
        .rr_ptr      (rr_ptr),
        .grant_valid (arb_valid),
        .grant_index (arb_index)
    );

    assign last_beat = (beat_cnt == len_q - LEN_WIDTH'(1));
    assign busy      = (state_q == SEND);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the unregistered stream path straight from the granted FIFO head.
    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        send_valid  = 1'b0;
        beat_hs     = 1'b0;
        fifo_rd_en  = '0;
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        axis.tkeep  = '1;
        axis.tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && arb_valid) begin
                    start   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                send_valid            = !fifo_empty[grant_idx];
                beat_hs               = send_valid && axis.tready;
                axis.tvalid           = send_valid;
                axis.tdata            = fifo_rd_data[grant_idx];
                axis.tlast            = last_beat;
                fifo_rd_en[grant_idx] = beat_hs;
                if (beat_hs && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant capture, beat counting, priority rotation and the completion pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            beat_cnt  <= '0;
            len_q     <= LEN_WIDTH'(1);
            pkt_done  <= 1'b0;
        end else begin
            pkt_done <= beat_hs && last_beat;
            if (start) begin
                grant_idx <= arb_index;
                len_q     <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
                beat_cnt  <= '0;
            end else if (beat_hs) begin
                if (last_beat) begin
                    rr_ptr <= (grant_idx == IW'(NUM_SRC - 1)) ? '0 : grant_idx + IW'(1);
                end else begin
                    beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo_rr_scheduler.sv
// Self-checking bench: bench-owned FWFT FIFOs and a cycle-level behavioural scheduler model.
module tb_axis_fifo_rr_scheduler;

    localparam int N     = 4;
    localparam int DW    = 64;
    localparam int LW    = 16;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic          tvalid;
        logic          tlast;
        logic [N-1:0]  rd_en;
        logic          busy;
        logic [1:0]    grant;
        logic          done;
        logic [7:0]    keep;
        logic [DW-1:0] data;
    } obs_t;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   enable;
    logic [LW-1:0]          pkt_len;
    logic [N-1:0][DW-1:0]   fifo_rd_data;
    logic [N-1:0]           fifo_empty;
    logic [N-1:0]           fifo_rd_en;
    logic                   busy;
    logic [1:0]             grant_idx;
    logic                   pkt_done;

    axi4s_if #(.DATA_WIDTH(DW)) axis_bus ();

    axis_fifo_rr_scheduler #(
        .NUM_SRC    (N),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .pkt_len      (pkt_len),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .axis         (axis_bus),
        .busy         (busy),
        .grant_idx    (grant_idx),
        .pkt_done     (pkt_done)
    );

    always #5 clk = ~clk;

    // Bench-owned FIFO contents
    logic [DW-1:0] mem [N][DEPTH];
    int            wr [N];
    int            rd [N];

    // Scheduler model state
    bit m_send;
    int m_src;
    int m_sent;
    int m_len;
    int m_ptr;
    bit m_done;

    obs_t         obs;
    obs_t         exp;
    int           checks;
    int           errors;
    int           pops [N];
    int           done_cnt;
    int           grant_log [$];
    logic [DW-1:0] last_log [$];
    bit           prev_busy;

    function automatic bool_t_dummy();
        return 0;
    endfunction

    function automatic void model_reset();
        m_send    = 1'b0;
        m_src     = 0;
        m_sent    = 0;
        m_len     = 1;
        m_ptr     = 0;
        m_done    = 1'b0;
        prev_busy = 1'b0;
    endfunction

    function automatic void clear_logs();
        for (int i = 0; i < N; i++) pops[i] = 0;
        done_cnt = 0;
        grant_log.delete();
        last_log.delete();
    endfunction

    function automatic void push(input int s, input logic [DW-1:0] w);
        mem[s][wr[s] % DEPTH] = w;
        wr[s]++;
    endfunction

    function automatic void refresh();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i]   = (wr[i] == rd[i]);
            fifo_rd_data[i] = (wr[i] == rd[i]) ? '0 : mem[i][rd[i] % DEPTH];
        end
    endfunction

    // One clock: present FIFO heads, sample DUT, predict, advance model, apply pops at negedge.
    task automatic step();
        bit           avail;
        bit           found;
        int           s;
        logic [N-1:0] pend;
        refresh();
        #1;
        obs.tvalid = axis_bus.tvalid;
        obs.tlast  = axis_bus.tlast;
        obs.rd_en  = fifo_rd_en;
        obs.busy   = busy;
        obs.grant  = grant_idx;
        obs.done   = pkt_done;
        obs.keep   = axis_bus.tkeep;
        obs.data   = axis_bus.tdata;

        avail     = m_send && (wr[m_src] != rd[m_src]);
        exp       = '0;
        exp.keep  = '1;
        exp.busy  = m_send;
        exp.grant = 2'(m_src);
        exp.done  = m_done;
        if (m_send) begin
            exp.tvalid = avail;
            exp.tlast  = (m_sent == m_len - 1);
            if (avail) exp.data = mem[m_src][rd[m_src] % DEPTH];
            if (avail && axis_bus.tready) exp.rd_en = N'(1) << m_src;
        end

        done_cnt += int'(pkt_done);
        for (int i = 0; i < N; i++) pops[i] += int'(fifo_rd_en[i]);
        if (busy && !prev_busy) grant_log.push_back(int'(grant_idx));
        prev_busy = busy;
        if (axis_bus.tvalid && axis_bus.tready && axis_bus.tlast) last_log.push_back(axis_bus.tdata);

        m_done = 1'b0;
        if (m_send) begin
            if (avail && axis_bus.tready) begin
                if (m_sent == m_len - 1) begin
                    m_send = 1'b0;
                    m_ptr  = (m_src + 1) % N;
                    m_done = 1'b1;
                end else begin
                    m_sent++;
                end
            end
        end else if (enable && rstn) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                s = (m_ptr + k) % N;
                if (!found && wr[s] != rd[s]) begin
                    found  = 1'b1;
                    m_src  = s;
                    m_len  = (pkt_len == 0) ? 1 : int'(pkt_len);
                    m_sent = 0;
                    m_send = 1'b1;
                end
            end
        end

        pend = fifo_rd_en;
        @(negedge clk);
        for (int i = 0; i < N; i++) if (pend[i] && wr[i] != rd[i]) rd[i]++;
    endtask

    task automatic apply_reset();
        rstn   = 1'b0;
        enable = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn            = 1'b0;
        enable          = 1'b0;
        pkt_len         = '0;
        axis_bus.tready = 1'b0;
        for (int i = 0; i < N; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_single_source();
        clear_logs();
        enable          = 1'b1;
        axis_bus.tready = 1'b1;
        pkt_len         = 16'd4;
        for (int i = 0; i < 8; i++) push(0, 64'hA000_0000_0000_0000 | 64'(i));
        for (int i = 0; i < 14; i++) begin
            step();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_src cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (pops[0] !== 8) begin
            errors++;
            $display("FAIL single_src pops: got %0d expected 8", pops[0]);
        end
        checks++;
        if (done_cnt !== 2) begin
            errors++;
            $display("FAIL single_src pkt_done count: got %0d expected 2", done_cnt);
        end
        checks++;
        if (last_log.size() !== 2) begin
            errors++;
            $display("FAIL single_src tlast count: got %0d expected 2", last_log.size());
        end else begin
            checks++;
            if (last_log[0] !== 64'hA000_0000_0000_0003 || last_log[1] !== 64'hA000_0000_0000_0007) begin
                errors++;
                $display("FAIL single_src tlast words: got %h %h expected A3 A7", last_log[0], last_log[1]);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        apply_reset();
        clear_logs();
        pkt_len = 16'd2;
        for (int s = 0; s < N; s++)
            for (int w = 0; w < 4; w++) push(s, {32'(s), $urandom});
        enable          = 1'b1;
        axis_bus.tready = 1'b1;
        for (int i = 0; i < 27; i++) begin
            step();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL round_robin cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (grant_log.size() !== 8) begin
            errors++;
            $display("FAIL round_robin grant count: got %0d expected 8", grant_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (grant_log[i] !== exp_order[i]) begin
                    errors++;
                    $display("FAIL round_robin grant %0d: got %0d expected %0d", i, grant_log[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit            rdy [7] = '{1, 1, 0, 0, 1, 1, 1};
        logic [DW-1:0] w [3];
        logic [DW-1:0] dat [7];
        logic          lst [7];
        logic [N-1:0]  ren [7];
        clear_logs();
        pkt_len = 16'd3;
        for (int i = 0; i < 3; i++) begin
            w[i] = {$urandom, $urandom};
            push(2, w[i]);
        end
        for (int i = 0; i < 7; i++) begin
            axis_bus.tready = rdy[i];
            step();
            dat[i] = obs.data;
            lst[i] = obs.tlast;
            ren[i] = obs.rd_en;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL backpressure cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
        for (int i = 2; i <= 4; i++) begin
            checks++;
            if (dat[i] !== w[1] || lst[i] !== 1'b0) begin
                errors++;
                $display("FAIL backpressure stall %0d: got data %h tlast %b expected %h 0", i, dat[i], lst[i], w[1]);
            end
        end
        checks++;
        if (ren[2] !== '0 || ren[3] !== '0) begin
            errors++;
            $display("FAIL backpressure stalled rd_en: got %b %b expected 0000", ren[2], ren[3]);
        end
        checks++;
        if (pops[2] !== 3 || lst[5] !== 1'b1) begin
            errors++;
            $display("FAIL backpressure totals: got pops %0d tlast %b expected 3 1", pops[2], lst[5]);
        end
    endtask

    task automatic test_starvation();
        logic [DW-1:0] w [5];
        clear_logs();
        axis_bus.tready = 1'b1;
        pkt_len         = 16'd5;
        for (int i = 0; i < 5; i++) w[i] = {32'h5151_0000, 32'(i)};
        push(1, w[0]);
        push(1, w[1]);
        push(2, 64'h2222_2222_2222_2222);
        for (int i = 0; i < 18; i++) begin
            if (i == 1) pkt_len = 16'd1;
            if (i == 10) for (int k = 2; k < 5; k++) push(1, w[k]);
            step();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL starvation cycle %0d: got %h expected %h", i, obs, exp);
            end
            if (i >= 3 && i <= 9) begin
                checks++;
                if (obs.tvalid !== 1'b0 || obs.grant !== 2'd1 || obs.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL starvation gap %0d: got tvalid %b grant %0d busy %b expected 0 1 1",
                             i, obs.tvalid, obs.grant, obs.busy);
                end
            end
        end
        checks++;
        if (last_log.size() < 1 || last_log[0] !== w[4]) begin
            errors++;
            $display("FAIL starvation tlast word: got %0d entries expected first %h", last_log.size(), w[4]);
        end
    endtask

    task automatic test_enable_len();
        clear_logs();
        axis_bus.tready = 1'b1;
        pkt_len         = 16'd0;
        for (int i = 0; i < 3; i++) push(3, {$urandom, $urandom});
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL len_zero cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (done_cnt !== 3 || last_log.size() !== 3) begin
            errors++;
            $display("FAIL len_zero packets: got done %0d tlast %0d expected 3 3", done_cnt, last_log.size());
        end

        clear_logs();
        pkt_len = 16'd4;
        for (int i = 0; i < 6; i++) push(0, {$urandom, $urandom});
        for (int i = 0; i < 12; i++) begin
            if (i == 2) enable = 1'b0;
            step();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL enable_drop cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (pops[0] !== 4 || obs.busy !== 1'b0 || grant_log.size() !== 1) begin
            errors++;
            $display("FAIL enable_drop totals: got pops %0d busy %b grants %0d expected 4 0 1",
                     pops[0], obs.busy, grant_log.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        enable          = 1'b1;
        axis_bus.tready = 1'b1;
        pkt_len         = 16'd4;
        for (int i = 0; i < 4; i++) push(1, {32'h1111_0000, 32'(i)});
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
        refresh();
        #1;
        checks++;
        if (axis_bus.tvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre: got tvalid %b expected 1", axis_bus.tvalid);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (axis_bus.tvalid !== 1'b0 || fifo_rd_en !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: got tvalid %b rd_en %b busy %b expected 0 0000 0",
                     axis_bus.tvalid, fifo_rd_en, busy);
        end
        model_reset();
        clear_logs();
        @(negedge clk);
        rstn    = 1'b1;
        pkt_len = 16'd2;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_restart cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
        checks++;
        if (grant_log.size() < 1 || grant_log[0] !== 0) begin
            errors++;
            $display("FAIL reset_restart first grant: got %0d entries expected grant 0", grant_log.size());
        end
    endtask

    task automatic test_random();
        int s;
        apply_reset();
        for (int i = 0; i < N; i++) rd[i] = wr[i];
        clear_logs();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                s = $urandom_range(0, N - 1);
                if (wr[s] - rd[s] < DEPTH - 8) push(s, {$urandom, $urandom});
            end
            axis_bus.tready = ($urandom_range(0, 3) != 0);
            enable          = ($urandom_range(0, 7) != 0);
            pkt_len         = LW'($urandom_range(0, 5));
            step();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_starvation();
        test_enable_len();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
